// File: rtl/f8_fetch_queue.sv
// f8 instruction prefetch queue: 2-byte fetches from split even/odd banks, 0-3 byte pops to decode.
// Optional performance counters are built when F8_FETCH_PERF_EN is defined.
module f8_fetch_queue #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned QDEPTH   = 8,
   parameter logic [31:0] RESET_PC = 32'h4000
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-2:0] mem_read_addr_even,
   input  logic [7:0]        mem_read_data_even,
   output logic [ADDR_W-2:0] mem_read_addr_odd,
   input  logic [7:0]        mem_read_data_odd,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [23:0]       peek_data,
   output logic [1:0]        peek_count,
   input  logic [1:0]        pop_len,
   output logic [ADDR_W-1:0] fetch_pc
`ifdef F8_FETCH_PERF_EN
   ,
   output logic [15:0]       starve_cycles,
   output logic [15:0]       redirect_count
`endif
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]    DEPTH_L = (CNT_W + 1)'(QDEPTH);
   localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);

   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              inflight_q, inflight_d;
   logic              req_odd_q, req_odd_d;
   logic [7:0]        mem_q [QDEPTH];
   logic [7:0]        mem_d [QDEPTH];

   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-2:0] bank_hi;
   logic [CNT_W:0]    need;
   logic              issue;
   logic [1:0]        pop_eff;
   logic [7:0]        ret_lo, ret_hi;
   logic [7:0]        byte0, byte1, byte2;

   // Request address and bank split; an odd start takes its second byte from the next even pair.
   always_comb begin
      req_addr = redirect ? redirect_pc : fetch_addr_q;
      bank_hi  = req_addr[ADDR_W-1:1];
      mem_read_addr_odd  = bank_hi;
      mem_read_addr_even = req_addr[0] ? bank_hi + (ADDR_W-1)'(1) : bank_hi;
   end

   // Space check counts bytes already queued plus the pair still in flight.
   always_comb begin
      need  = {1'b0, count_q} + {{(CNT_W-1){1'b0}}, inflight_q, 1'b0} + (CNT_W + 1)'(2);
      issue = reset && (redirect || (need <= DEPTH_L));
   end

   always_comb begin
      peek_count = (count_q >= CNT_W'(3)) ? 2'd3 : count_q[1:0];
      byte0 = mem_q[rd_ptr_q];
      byte1 = mem_q[rd_ptr_q + PTR_W'(1)];
      byte2 = mem_q[rd_ptr_q + PTR_W'(2)];
      peek_data = '0;
      if (peek_count >= 2'd1) peek_data[7:0]   = byte0;
      if (peek_count >= 2'd2) peek_data[15:8]  = byte1;
      if (peek_count == 2'd3) peek_data[23:16] = byte2;
      pop_eff  = (pop_len > peek_count) ? peek_count : pop_len;
      fetch_pc = fetch_pc_q;
   end

   always_comb begin
      ret_lo = req_odd_q ? mem_read_data_odd  : mem_read_data_even;
      ret_hi = req_odd_q ? mem_read_data_even : mem_read_data_odd;
   end

   always_comb begin
      fetch_addr_d = fetch_addr_q;
      fetch_pc_d   = fetch_pc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      inflight_d   = 1'b0;
      req_odd_d    = req_odd_q;
      mem_d        = mem_q;

      if (redirect) begin
         // Flush: any pair returning now belongs to the old stream and is dropped.
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (inflight_q) begin
            mem_d[wr_ptr_q]              = ret_lo;
            mem_d[wr_ptr_q + PTR_W'(1)]  = ret_hi;
            wr_ptr_d = wr_ptr_q + PTR_W'(2);
         end
         rd_ptr_d   = rd_ptr_q + PTR_W'(pop_eff);
         count_d    = count_q + (inflight_q ? CNT_W'(2) : '0) - CNT_W'(pop_eff);
         fetch_pc_d = fetch_pc_q + ADDR_W'(pop_eff);
      end

      if (issue) begin
         inflight_d   = 1'b1;
         fetch_addr_d = req_addr + ADDR_W'(2);
         req_odd_d    = req_addr[0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_addr_q <= RST_PC;
         fetch_pc_q   <= RST_PC;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         inflight_q   <= 1'b0;
         req_odd_q    <= 1'b0;
      end else begin
         fetch_addr_q <= fetch_addr_d;
         fetch_pc_q   <= fetch_pc_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
         req_odd_q    <= req_odd_d;
      end
   end

   // Byte storage needs no reset; count gates every read of it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef F8_FETCH_PERF_EN
   logic [15:0] starve_q, starve_d;
   logic [15:0] redir_cnt_q, redir_cnt_d;

   always_comb begin
      starve_d    = starve_q;
      redir_cnt_d = redir_cnt_q;
      if (redirect) begin
         if (redir_cnt_q != 16'hFFFF) redir_cnt_d = redir_cnt_q + 16'd1;
      end else if (peek_count == 2'd0 && starve_q != 16'hFFFF) begin
         starve_d = starve_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_q    <= '0;
         redir_cnt_q <= '0;
      end else begin
         starve_q    <= starve_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign starve_cycles  = starve_q;
   assign redirect_count = redir_cnt_q;
`endif

endmodule

// File: doc/f8_fetch_queue.md
Name: f8_fetch_queue

Overview:
- Parametrised instruction prefetch queue for the f8 core.
- Fetches 2 bytes per cycle from the split even/odd byte-bank memory, at aligned or unaligned addresses.
- Buffers the bytes in a FIFO and presents up to 3 bytes of the instruction stream to decode, which pops 0-3 bytes per cycle.
- Replaces the fixed single-instruction fetch in the core; handles variable-length instructions and redirects (jumps) generically.

Parameters:
ADDR_W, 16, byte address width; bank address width is ADDR_W-1
QDEPTH, 8, queue capacity in bytes; power of 2, minimum 4
RESET_PC, 16'h4000, fetch address loaded on reset (truncated to ADDR_W)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous reset, active-low (0 = reset asserted at the edge)
mem_read_addr_even  out  ADDR_W-1  even-bank byte-pair address; synchronous read, data next cycle
mem_read_data_even  in  8  even-bank read data
mem_read_addr_odd  out  ADDR_W-1  odd-bank byte-pair address
mem_read_data_odd  in  8  odd-bank read data
redirect  in  1  flush the queue and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new stream address
peek_data  out  24  next 3 stream bytes; [7:0] is at fetch_pc; bytes beyond peek_count read 0
peek_count  out  2  valid bytes in peek_data, min(count,3)
pop_len  in  2  bytes consumed this cycle, 0-3
fetch_pc  out  ADDR_W  byte address of peek_data[7:0]

Behaviour:
- State:
  - fetch_addr: next byte address to request.
  - fetch_pc: address of the queue head.
  - Byte FIFO with rd/wr pointers and count (0..QDEPTH).
  - inflight flag: request issued last cycle.
- Reset (reset==0 at edge):
  - fetch_addr = fetch_pc = RESET_PC; count = 0; pointers = 0; inflight = 0.
  - Combinational outputs then read peek_count = 0, peek_data = 0.
  - No request is issued while reset is low; the data returned in the first cycle after release is ignored.
- Request address A:
  - A = redirect ? redirect_pc : fetch_addr.
  - A[0]==0: even = A[ADDR_W-1:1], odd = A[ADDR_W-1:1].
  - A[0]==1: odd = A[ADDR_W-1:1], even = A[ADDR_W-1:1]+1, wrapping modulo 2^(ADDR_W-1).
  - Bank address outputs are driven every cycle; they are meaningful only when issuing.
- Issue rule:
  - Issue when reset==1 and (redirect or count + 2*inflight + 2 <= QDEPTH).
  - On issue: inflight_next = 1 and fetch_addr_next = A+2, modulo 2^ADDR_W (0xFFFF+2 wraps to 0x0001).
- Data return (inflight==1 and no redirect this cycle):
  - Push 2 bytes, low byte first.
  - Low byte = A[0] ? odd : even, high byte = A[0] ? even : odd, where A is the address of the returning request.
- Pop:
  - Effective pop = min(pop_len, peek_count); over-pop is clamped, never corrupts the pointers.
  - fetch_pc += effective pop, modulo 2^ADDR_W.
- Push and pop in the same cycle:
  - Both apply; count_next = count + push - pop.
  - The issue rule guarantees no overflow, since pops only reduce count.
- Redirect (reset==1, redirect==1):
  - Queue emptied; count = 0; fetch_pc = redirect_pc; pop_len ignored.
  - Data returning this cycle from an older request is discarded.
  - A new request is issued from redirect_pc in the same cycle.
- Latency:
  - Redirect or reset release in cycle N: data returns in N+1 and peek_count reaches 2 in N+2.
  - Steady state sustains 2 bytes/cycle.
- Bytes are never reordered. The stream is contiguous from fetch_pc until the next redirect.

Optional Feature:
- Macro F8_FETCH_PERF_EN.
- When defined:
  - Adds output starve_cycles [15:0]. Reset value is 0.
  - Increments, saturating at 16'hFFFF, on each cycle with reset==1, no redirect, and peek_count==0.
  - Also adds output redirect_count [15:0], a saturating count of accepted redirects.
- When undefined, neither port exists and there is no added logic.

Test Plan:
- Memory model: byte at address B = B[7:0] ^ B[15:8].
- Reset release, pop_len=0 -> peek_count 0,0,2,3; after 4 fetches count saturates at QDEPTH=8, no further issue; peek_data = {0x42,0x41,0x40} at 0x4000 (byte 0x4002 on [23:16]); fetch_pc=0x4000.
- Unaligned redirect to 0x4001 -> that cycle odd addr=0x2000, even addr=0x2001; two cycles later peek_data[15:0] = {0x42,0x41}.
- Continuous pop_len=2 after fill -> peek_count never drops to 0; fetch_pc advances exactly 2/cycle; byte sequence contiguous over 64 bytes.
- Redirect while inflight, to 0x1234 -> stale bytes never appear; peek_data[7:0]=0x26 (0x34^0x12); fetch_pc=0x1234.
- Redirect to 0xFFFF -> odd addr=0x7FFF, even addr=0x0000; stream bytes at 0xFFFF then 0x0000 = {0x00,0x00}; fetch_pc wraps 0xFFFF -> 0x0000 on pop 1.
- pop_len=3 with peek_count=1 -> pop clamped to 1; fetch_pc +1; count never underflows; with F8_FETCH_PERF_EN, starve_cycles increments on each subsequent empty cycle.
